// File: rtl/traffic_pkg.sv
// Shared types and lamp encodings for the multi-approach traffic controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    S_ALL_RED,
    S_GREEN,
    S_YELLOW,
    S_FLASH
  } state_t;

  // One {R,Y,G} lamp triple per approach.
  localparam logic [2:0] LED_RED = 3'b100;
  localparam logic [2:0] LED_YEL = 3'b010;
  localparam logic [2:0] LED_GRN = 3'b001;
  localparam logic [2:0] LED_OFF = 3'b000;

  // Bit positions inside a lamp triple.
  localparam int LAMP_RED = 2;
  localparam int LAMP_YEL = 1;
  localparam int LAMP_GRN = 0;

endpackage

// File: rtl/tick_prescaler.sv
// Divides masterclk down to a single-cycle timing tick every TICK_DIV cycles.
module tick_prescaler #(
  parameter int TICK_DIV = 1
) (
  input  logic masterclk,
  input  logic reset_button,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running modulo-TICK_DIV counter; the tick marks its last count.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge masterclk) begin
    if (reset_button) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // With TICK_DIV=1 the counter stays at zero and the tick is always high.
  assign tick = (cnt == LAST);

endmodule

// File: rtl/multi_approach_traffic_controller.sv
// N-approach intersection controller. Approach 0 (main street) rests green;
// side approaches are served round-robin on latched demand, with min/max
// green, gap-out, yellow, all-red clearance and a night flash mode.
// YELLOW_TICKS, ALL_RED_TICKS and FLASH_TICKS must not exceed MAX_GREEN+1,
// because the shared state timer saturates at MAX_GREEN.
module multi_approach_traffic_controller
  import traffic_pkg::*;
#(
  parameter int NUM_APPROACHES = 4,
  parameter int TICK_DIV       = 1,
  parameter int MIN_GREEN      = 4,
  parameter int MAX_GREEN      = 10,
  parameter int YELLOW_TICKS   = 3,
  parameter int ALL_RED_TICKS  = 2,
  parameter int FLASH_TICKS    = 5
) (
  input  logic                              masterclk,
  input  logic                              reset_button,
  input  logic [NUM_APPROACHES-1:0]         sensor_button,
  input  logic                              flash_en,
  output logic [3*NUM_APPROACHES-1:0]       leds,
  output logic [$clog2(NUM_APPROACHES)-1:0] green_idx,
  output logic                              flashing
);

  localparam int IW = $clog2(NUM_APPROACHES);
  localparam int TW = $clog2(MAX_GREEN + 1);

  typedef logic [IW-1:0] idx_t;
  typedef logic [TW-1:0] tmr_t;

  // A K-tick state ends on the tick that sees timer == K-1.
  localparam tmr_t MAX_T    = tmr_t'(MAX_GREEN);
  localparam tmr_t MIN_LAST = tmr_t'(MIN_GREEN - 1);
  localparam tmr_t MAX_LAST = tmr_t'(MAX_GREEN - 1);
  localparam tmr_t YEL_LAST = tmr_t'(YELLOW_TICKS - 1);
  localparam tmr_t AR_LAST  = tmr_t'(ALL_RED_TICKS - 1);
  localparam tmr_t FL_LAST  = tmr_t'(FLASH_TICKS - 1);

  state_t                      state;
  idx_t                        cur;        // approach owning GREEN/YELLOW
  idx_t                        nxt;        // approach to serve after ALL_RED
  logic [NUM_APPROACHES-1:0]   req;
  tmr_t                        timer;
  logic                        flash_lit;
  logic                        tick;
  tmr_t                        tmr_inc;
  idx_t                        rr_pick;
  logic                        rr_found;
  logic                        green_done;
  logic [3*NUM_APPROACHES-1:0] lamp_vec;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .masterclk    (masterclk),
    .reset_button (reset_button),
    .tick         (tick)
  );

  // Saturating timer increment.
  assign tmr_inc = (timer == MAX_T) ? timer : timer + 1'b1;

  // Round-robin scan of latched requests starting just after the current approach.
  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    rr_pick  = '0;
    rr_found = 1'b0;
    for (int off = 1; off < NUM_APPROACHES; off++) begin
      if (!rr_found && req[(int'(cur) + off) % NUM_APPROACHES]) begin
        rr_pick  = idx_t'((int'(cur) + off) % NUM_APPROACHES);
        rr_found = 1'b1;
      end
    end
  end

  // Green exit: flash overrides minimum green; main leaves only for side demand;
  // a side approach maxes out or gaps out once its sensor drops.
  always_comb begin
    if (flash_en) begin
      green_done = 1'b1;
    end else if (cur == '0) begin
      green_done = (timer >= MIN_LAST) && (|req[NUM_APPROACHES-1:1]);
    end else begin
      green_done = (timer == MAX_LAST) ||
                   ((timer >= MIN_LAST) && !sensor_button[cur]);
    end
  end

  // Lamp pattern for the current (registered) state; registered again into leds.
  always_comb begin
    lamp_vec = {NUM_APPROACHES{LED_RED}};
    case (state)
      S_GREEN:  lamp_vec[int'(cur)*3 +: 3] = LED_GRN;
      S_YELLOW: lamp_vec[int'(cur)*3 +: 3] = LED_YEL;
      S_FLASH: begin
        for (int i = 0; i < NUM_APPROACHES; i++) begin
          lamp_vec[i*3 +: 3] = !flash_lit ? LED_OFF : ((i == 0) ? LED_YEL : LED_RED);
        end
      end
      default: ;
    endcase
  end

  // Controller FSM, request latch and registered outputs.
  always_ff @(posedge masterclk) begin
    if (reset_button) begin
      state     <= S_ALL_RED;
      cur       <= '0;
      nxt       <= '0;
      req       <= '0;
      timer     <= '0;
      flash_lit <= 1'b0;
      leds      <= {NUM_APPROACHES{LED_RED}};
      green_idx <= '0;
      flashing  <= 1'b0;
    end else begin
      leds      <= lamp_vec;
      green_idx <= (state == S_GREEN || state == S_YELLOW) ? cur : '0;
      flashing  <= (state == S_FLASH);

      // Demand latch; the approach holding green does not re-request itself.
      for (int i = 0; i < NUM_APPROACHES; i++) begin
        if (state == S_FLASH) begin
          req[i] <= 1'b0;
        end else if (sensor_button[i] && !(state == S_GREEN && int'(cur) == i)) begin
          req[i] <= 1'b1;
        end
      end

      case (state)
        S_ALL_RED: begin
          if (tick) begin
            if (timer == AR_LAST) begin
              timer <= '0;
              if (flash_en) begin
                state     <= S_FLASH;
                flash_lit <= 1'b1;
              end else begin
                state    <= S_GREEN;
                cur      <= nxt;
                req[nxt] <= 1'b0;
              end
            end else begin
              timer <= tmr_inc;
            end
          end
        end

        S_GREEN: begin
          if (tick) begin
            if (green_done) begin
              state <= S_YELLOW;
              timer <= '0;
            end else begin
              timer <= tmr_inc;
            end
          end
        end

        S_YELLOW: begin
          if (tick) begin
            if (timer == YEL_LAST) begin
              state <= S_ALL_RED;
              timer <= '0;
              nxt   <= rr_pick;
            end else begin
              timer <= tmr_inc;
            end
          end
        end

        S_FLASH: begin
          if (!flash_en) begin
            state     <= S_ALL_RED;
            nxt       <= '0;
            timer     <= '0;
            flash_lit <= 1'b0;
          end else if (tick) begin
            if (timer == FL_LAST) begin
              timer     <= '0;
              flash_lit <= !flash_lit;
            end else begin
              timer <= tmr_inc;
            end
          end
        end

        default: begin
          state <= S_ALL_RED;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_approach_traffic_controller.sv
// Directed bench for the multi-approach controller: one instance at TICK_DIV=1
// and one at TICK_DIV=4, sharing a clock. Lamp durations are measured as run
// lengths of the full leds vector sampled 1 ns after each rising edge.
module tb_multi_approach_traffic_controller;

  localparam int N = 4;
  typedef logic [3*N-1:0] lv_t;

  localparam lv_t ALL_RED   = {N{3'b100}};
  localparam lv_t FLASH_LIT = {3'b100, 3'b100, 3'b100, 3'b010};
  localparam lv_t FLASH_OFF = '0;

  logic       masterclk = 1'b0;
  logic       rst, rst4;
  logic [N-1:0] sensor, sensor4;
  logic       flash_en, flash_en4;
  lv_t        leds, leds4;
  logic [1:0] gidx, gidx4;
  logic       flashing, flashing4;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 masterclk = ~masterclk;

  multi_approach_traffic_controller #(
    .NUM_APPROACHES(N), .TICK_DIV(1), .MIN_GREEN(4), .MAX_GREEN(10),
    .YELLOW_TICKS(3), .ALL_RED_TICKS(2), .FLASH_TICKS(5)
  ) dut (
    .masterclk(masterclk), .reset_button(rst), .sensor_button(sensor),
    .flash_en(flash_en), .leds(leds), .green_idx(gidx), .flashing(flashing)
  );

  multi_approach_traffic_controller #(
    .NUM_APPROACHES(N), .TICK_DIV(4), .MIN_GREEN(4), .MAX_GREEN(10),
    .YELLOW_TICKS(3), .ALL_RED_TICKS(2), .FLASH_TICKS(5)
  ) dut4 (
    .masterclk(masterclk), .reset_button(rst4), .sensor_button(sensor4),
    .flash_en(flash_en4), .leds(leds4), .green_idx(gidx4), .flashing(flashing4)
  );

  function automatic lv_t lamp(input int a, input logic [2:0] p);
    lv_t v;
    v = ALL_RED;
    v[3*a +: 3] = p;
    return v;
  endfunction

  function automatic lv_t obs(input bit sel);
    return sel ? leds4 : leds;
  endfunction

  task automatic step();
    @(posedge masterclk);
    #1;
  endtask

  // Count consecutive samples equal to want, starting with the current one.
  task automatic run_len(input bit sel, input lv_t want, input int budget, output int len);
    len = 0;
    while (obs(sel) == want && len < budget) begin
      len++;
      step();
    end
  endtask

  task automatic wait_for(input bit sel, input lv_t want, input int budget, output bit hit);
    int n;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < budget) begin
      if (obs(sel) == want) hit = 1'b1;
      else begin
        step();
        n++;
      end
    end
  endtask

  task automatic test_reset();
    int len;
    rst = 1'b1;
    repeat (3) step();
    total_cnt++; if (leds !== ALL_RED) $display("FAIL reset_leds: got %b want %b", leds, ALL_RED); else pass_cnt++;
    total_cnt++; if (gidx !== 2'd0) $display("FAIL reset_gidx: got %0d want 0", gidx); else pass_cnt++;
    total_cnt++; if (flashing !== 1'b0) $display("FAIL reset_flashing: got %b want 0", flashing); else pass_cnt++;
    rst = 1'b0;
    step();
    run_len(0, ALL_RED, 20, len);
    total_cnt++; if (len !== 2) $display("FAIL startup_allred_len: got %0d want 2", len); else pass_cnt++;
    total_cnt++; if (leds !== lamp(0, 3'b001)) $display("FAIL startup_main_green: got %b want %b", leds, lamp(0, 3'b001)); else pass_cnt++;
    run_len(0, lamp(0, 3'b001), 50, len);
    total_cnt++; if (len !== 50) $display("FAIL main_rests_green: got %0d want 50", len); else pass_cnt++;
  endtask

  task automatic test_gap_out();
    int len;
    sensor = 4'b0100;
    step();
    sensor = 4'b0000;
    run_len(0, lamp(0, 3'b001), 10, len);
    total_cnt++; if (len !== 2) $display("FAIL t2_main_hold: got %0d want 2", len); else pass_cnt++;
    run_len(0, lamp(0, 3'b010), 10, len);
    total_cnt++; if (len !== 3) $display("FAIL t2_main_yellow: got %0d want 3", len); else pass_cnt++;
    run_len(0, ALL_RED, 10, len);
    total_cnt++; if (len !== 2) $display("FAIL t2_allred1: got %0d want 2", len); else pass_cnt++;
    total_cnt++; if (gidx !== 2'd2) $display("FAIL t2_gidx_green: got %0d want 2", gidx); else pass_cnt++;
    run_len(0, lamp(2, 3'b001), 20, len);
    total_cnt++; if (len !== 4) $display("FAIL t2_gapout_len: got %0d want 4", len); else pass_cnt++;
    total_cnt++; if (gidx !== 2'd2) $display("FAIL t2_gidx_yellow: got %0d want 2", gidx); else pass_cnt++;
    run_len(0, lamp(2, 3'b010), 10, len);
    total_cnt++; if (len !== 3) $display("FAIL t2_side_yellow: got %0d want 3", len); else pass_cnt++;
    run_len(0, ALL_RED, 10, len);
    total_cnt++; if (len !== 2) $display("FAIL t2_allred2: got %0d want 2", len); else pass_cnt++;
    total_cnt++; if (leds !== lamp(0, 3'b001)) $display("FAIL t2_back_to_main: got %b want %b", leds, lamp(0, 3'b001)); else pass_cnt++;
  endtask

  task automatic test_max_out();
    int len;
    sensor = 4'b0010;
    run_len(0, lamp(0, 3'b001), 10, len);
    run_len(0, lamp(0, 3'b010), 10, len);
    total_cnt++; if (len !== 3) $display("FAIL t3_main_yellow: got %0d want 3", len); else pass_cnt++;
    run_len(0, ALL_RED, 10, len);
    total_cnt++; if (len !== 2) $display("FAIL t3_allred1: got %0d want 2", len); else pass_cnt++;
    // Sensor held through green; dropped right after the tenth green sample.
    len = 0;
    while (leds == lamp(1, 3'b001) && len < 20) begin
      len++;
      if (len == 10) sensor = 4'b0000;
      step();
    end
    sensor = 4'b0000;
    total_cnt++; if (len !== 10) $display("FAIL t3_maxout_len: got %0d want 10", len); else pass_cnt++;
    run_len(0, lamp(1, 3'b010), 10, len);
    total_cnt++; if (len !== 3) $display("FAIL t3_side_yellow: got %0d want 3", len); else pass_cnt++;
    run_len(0, ALL_RED, 10, len);
    total_cnt++; if (len !== 2) $display("FAIL t3_allred2: got %0d want 2", len); else pass_cnt++;
    run_len(0, lamp(0, 3'b001), 20, len);
    total_cnt++; if (len !== 20) $display("FAIL t3_main_rests: got %0d want 20", len); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int len;
    sensor = 4'b1010;
    step();
    sensor = 4'b0000;
    run_len(0, lamp(0, 3'b001), 10, len);
    run_len(0, lamp(0, 3'b010), 10, len);
    total_cnt++; if (len !== 3) $display("FAIL t4_main_yellow: got %0d want 3", len); else pass_cnt++;
    run_len(0, ALL_RED, 10, len);
    total_cnt++; if (len !== 2) $display("FAIL t4_allred_a: got %0d want 2", len); else pass_cnt++;
    total_cnt++; if (gidx !== 2'd1) $display("FAIL t4_first_served: got %0d want 1", gidx); else pass_cnt++;
    run_len(0, lamp(1, 3'b001), 20, len);
    total_cnt++; if (len !== 4) $display("FAIL t4_green1_len: got %0d want 4", len); else pass_cnt++;
    run_len(0, lamp(1, 3'b010), 10, len);
    total_cnt++; if (len !== 3) $display("FAIL t4_yellow1: got %0d want 3", len); else pass_cnt++;
    run_len(0, ALL_RED, 10, len);
    total_cnt++; if (len !== 2) $display("FAIL t4_allred_b: got %0d want 2", len); else pass_cnt++;
    total_cnt++; if (gidx !== 2'd3) $display("FAIL t4_second_served: got %0d want 3", gidx); else pass_cnt++;
    run_len(0, lamp(3, 3'b001), 20, len);
    total_cnt++; if (len !== 4) $display("FAIL t4_green3_len: got %0d want 4", len); else pass_cnt++;
    run_len(0, lamp(3, 3'b010), 10, len);
    total_cnt++; if (len !== 3) $display("FAIL t4_yellow3: got %0d want 3", len); else pass_cnt++;
    run_len(0, ALL_RED, 10, len);
    total_cnt++; if (len !== 2) $display("FAIL t4_allred_c: got %0d want 2", len); else pass_cnt++;
    total_cnt++; if (leds !== lamp(0, 3'b001)) $display("FAIL t4_back_to_main: got %b want %b", leds, lamp(0, 3'b001)); else pass_cnt++;
  endtask

  task automatic test_flash();
    int len;
    bit hit;
    sensor = 4'b0100;
    step();
    sensor = 4'b0000;
    wait_for(0, lamp(2, 3'b001), 30, hit);
    total_cnt++; if (hit !== 1'b1) $display("FAIL t5_reach_side_green: got %b want 1", hit); else pass_cnt++;
    flash_en = 1'b1;
    run_len(0, lamp(2, 3'b001), 20, len);
    total_cnt++; if (len !== 2) $display("FAIL t5_forced_green_len: got %0d want 2", len); else pass_cnt++;
    run_len(0, lamp(2, 3'b010), 10, len);
    total_cnt++; if (len !== 3) $display("FAIL t5_yellow: got %0d want 3", len); else pass_cnt++;
    run_len(0, ALL_RED, 10, len);
    total_cnt++; if (len !== 2) $display("FAIL t5_allred_in: got %0d want 2", len); else pass_cnt++;
    total_cnt++; if (flashing !== 1'b1) $display("FAIL t5_flashing_hi: got %b want 1", flashing); else pass_cnt++;
    run_len(0, FLASH_LIT, 20, len);
    total_cnt++; if (len !== 5) $display("FAIL t5_lit_len: got %0d want 5", len); else pass_cnt++;
    run_len(0, FLASH_OFF, 20, len);
    total_cnt++; if (len !== 5) $display("FAIL t5_off_len: got %0d want 5", len); else pass_cnt++;
    total_cnt++; if (leds !== FLASH_LIT) $display("FAIL t5_relit: got %b want %b", leds, FLASH_LIT); else pass_cnt++;
    flash_en = 1'b0;
    run_len(0, FLASH_LIT, 10, len);
    run_len(0, ALL_RED, 10, len);
    total_cnt++; if (len !== 2) $display("FAIL t5_allred_out: got %0d want 2", len); else pass_cnt++;
    total_cnt++; if (leds !== lamp(0, 3'b001)) $display("FAIL t5_main_after_flash: got %b want %b", leds, lamp(0, 3'b001)); else pass_cnt++;
    total_cnt++; if (flashing !== 1'b0) $display("FAIL t5_flashing_lo: got %b want 0", flashing); else pass_cnt++;
  endtask

  task automatic test_prescaled();
    int len;
    rst4 = 1'b1;
    step();
    rst4 = 1'b0;
    step();
    run_len(1, ALL_RED, 40, len);
    total_cnt++; if (len !== 8) $display("FAIL t6_startup_allred: got %0d want 8", len); else pass_cnt++;
    total_cnt++; if (leds4 !== lamp(0, 3'b001)) $display("FAIL t6_main_green: got %b want %b", leds4, lamp(0, 3'b001)); else pass_cnt++;
    sensor4 = 4'b0010;
    step();
    sensor4 = 4'b0000;
    // One of the 16 main-green samples is already behind us.
    run_len(1, lamp(0, 3'b001), 40, len);
    total_cnt++; if (len !== 15) $display("FAIL t6_min_green: got %0d want 15", len); else pass_cnt++;
    run_len(1, lamp(0, 3'b010), 40, len);
    total_cnt++; if (len !== 12) $display("FAIL t6_yellow: got %0d want 12", len); else pass_cnt++;
    run_len(1, ALL_RED, 40, len);
    total_cnt++; if (len !== 8) $display("FAIL t6_allred: got %0d want 8", len); else pass_cnt++;
    run_len(1, lamp(1, 3'b001), 60, len);
    total_cnt++; if (len !== 16) $display("FAIL t6_gapout: got %0d want 16", len); else pass_cnt++;
    total_cnt++; if (gidx4 !== 2'd1) $display("FAIL t6_gidx_yellow: got %0d want 1", gidx4); else pass_cnt++;
    repeat (5) step();
    rst4 = 1'b1;
    step();
    total_cnt++; if (leds4 !== ALL_RED) $display("FAIL t6_midyellow_reset: got %b want %b", leds4, ALL_RED); else pass_cnt++;
    total_cnt++; if (gidx4 !== 2'd0) $display("FAIL t6_reset_gidx: got %0d want 0", gidx4); else pass_cnt++;
    rst4 = 1'b0;
    step();
    run_len(1, ALL_RED, 40, len);
    total_cnt++; if (len !== 8) $display("FAIL t6_clearance: got %0d want 8", len); else pass_cnt++;
    total_cnt++; if (leds4 !== lamp(0, 3'b001)) $display("FAIL t6_main_after_reset: got %b want %b", leds4, lamp(0, 3'b001)); else pass_cnt++;
  endtask

  initial begin
    rst       = 1'b1;
    rst4      = 1'b1;
    sensor    = '0;
    sensor4   = '0;
    flash_en  = 1'b0;
    flash_en4 = 1'b0;
    test_reset();
    test_gap_out();
    test_max_out();
    test_back_to_back();
    test_flash();
    test_prescaled();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
